// File: rtl/fifo_pkg.sv
// Types and helpers shared by the FIFO read-side blocks: the unpacker FSM
// encoding and the legality check for the entry/sub-word split.
package fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } unpack_state_e;

    function automatic bit ratio_legal(input int in_w, input int ratio);
        return (ratio == 1 || ratio == 2 || ratio == 4 || ratio == 8) &&
               (in_w > 0) && (in_w % ratio == 0);
    endfunction

endpackage

// File: rtl/fifo_rd_unpacker.sv
// Pops one entry from a show-ahead FIFO and presents it as RATIO narrower
// sub-words, least-significant lane first, with a zero-bubble handoff between entries.
module fifo_rd_unpacker
    import fifo_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int RATIO = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    fifo_empty_i,
    input  logic [IN_W-1:0]         fifo_data_i,
    output logic                    fifo_pop_o,
    output logic                    out_valid_o,
    output logic [IN_W/RATIO-1:0]   out_data_o,
    output logic                    out_last_o,
    input  logic                    out_ready_i,
    output logic                    busy_o
);

    localparam int OUT_W  = IN_W / RATIO;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    if (!ratio_legal(IN_W, RATIO)) begin : g_bad_params
        $error("fifo_rd_unpacker: IN_W must split evenly into RATIO lanes of 1, 2, 4 or 8");
    end

    unpack_state_e                state_q, state_d;
    logic [IN_W-1:0]              hold_q, hold_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    logic [RATIO-1:0][OUT_W-1:0]  lanes;
    logic                         in_hold;
    logic                         is_last;
    logic                         transfer;
    logic                         pop;

    assign lanes    = hold_q;
    // Reset is folded into the outputs so nothing is offered or popped while it is held.
    assign in_hold  = (state_q == HOLD) && !rst_i;
    assign is_last  = (lane_q == LAST_LANE);
    assign transfer = in_hold && out_ready_i;
    assign pop      = !rst_i && !flush_i && !fifo_empty_i &&
                      ((state_q == IDLE) || (transfer && is_last));

    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        lane_d  = lane_q;
        if (flush_i) begin
            state_d = IDLE;
            lane_d  = '0;
        end else if (pop) begin
            state_d = HOLD;
            hold_d  = fifo_data_i;
            lane_d  = '0;
        end else if (transfer) begin
            if (is_last) begin
                state_d = IDLE;
                lane_d  = '0;
            end else begin
                lane_d  = lane_q + LANE_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lane_q  <= '0;
            // NOTE: the holding register is cleared too, so out_data_o reads zero after reset.
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            hold_q  <= hold_d;
        end
    end

    assign fifo_pop_o  = pop;
    assign out_valid_o = in_hold;
    assign busy_o      = in_hold;
    assign out_data_o  = lanes[lane_q];
    // Gated by valid so a single-lane build does not flag last while idle.
    assign out_last_o  = in_hold && is_last;

endmodule

// File: doc/fifo_rd_unpacker.md
FIFO_RD_UNPACKER -- requirements
Module: fifo_rd_unpacker

Interface
REQ-001 Parameter IN_W, default 32, width of one FIFO entry in bits.
REQ-002 Parameter RATIO, default 4, number of output sub-words per entry; legal values 1, 2, 4, 8; IN_W % RATIO == 0.
REQ-003 Derived constant OUT_W = IN_W/RATIO; this is not user-overridable.
REQ-004 clk_i  in  1  single clock; all logic is rising-edge.
REQ-005 rst_i  in  1  synchronous reset, active-high.
REQ-006 flush_i  in  1  discards the held entry and aborts the current unpack.
REQ-007 fifo_empty_i  in  1  empty flag from the show-ahead FIFO.
REQ-008 fifo_data_i  in  IN_W  show-ahead head entry, valid whenever fifo_empty_i=0.
REQ-009 fifo_pop_o  out  1  pop request to the FIFO; one entry is consumed per cycle it is high.
REQ-010 out_valid_o  out  1  out_data_o holds a valid sub-word.
REQ-011 out_data_o  out  OUT_W  current sub-word, least-significant lane first.
REQ-012 out_last_o  out  1  current sub-word is lane RATIO-1 of its entry.
REQ-013 out_ready_i  in  1  downstream accepts the sub-word.
REQ-014 busy_o  out  1  holding register is occupied.

Function
REQ-015 Internal state is a holding register hold_q[IN_W], a lane counter lane_q[max(1,log2 RATIO)] and a two-state FSM: IDLE (no entry held) and HOLD (entry held).
REQ-016 A transfer occurs in any cycle where out_valid_o=1 and out_ready_i=1; no other event advances the lane.
REQ-017 out_valid_o=1 exactly when the FSM is in HOLD; busy_o equals out_valid_o.
REQ-018 out_data_o = hold_q[lane_q*OUT_W +: OUT_W]; out_last_o = (lane_q == RATIO-1).
REQ-019 fifo_pop_o = !flush_i && !fifo_empty_i && (state==IDLE || (transfer && out_last_o)); it is never asserted while fifo_empty_i=1.
REQ-020 On pop, hold_q loads fifo_data_i, lane_q becomes 0, and the next state is HOLD.
REQ-021 On a transfer that is not the last lane, lane_q increments by 1 and hold_q is unchanged.
REQ-022 On a transfer on the last lane with no pop, the next state is IDLE and lane_q becomes 0.
REQ-023 A last-lane transfer and a pop in the same cycle keep the state in HOLD, giving zero-bubble back-to-back entries.
REQ-024 Latency: a pop at edge N makes out_valid_o high from cycle N+1; steady-state throughput is one sub-word per cycle.
REQ-025 While out_valid_o=1 and out_ready_i=0, out_valid_o, out_data_o and out_last_o hold stable; only flush_i or rst_i may drop them.
REQ-026 flush_i has priority over the transfer and the pop: the next state is IDLE, lane_q becomes 0 and fifo_pop_o=0 that cycle; a transfer handshake coinciding with the flush is considered consumed.
REQ-027 When RATIO=1, every transfer has out_last_o=1 and the block acts as a one-entry pipelined read stage.
REQ-028 The lane counter never exceeds RATIO-1; wrap-around occurs only through REQ-020/REQ-022.

Reset
REQ-029 During rst_i=1 at a clock edge, the state becomes IDLE, lane_q becomes 0, and hold_q becomes 0.
REQ-030 During reset and in the first cycle after it, out_valid_o=0, out_last_o=0, busy_o=0 and fifo_pop_o=0; out_data_o=0.
REQ-031 Reset asserted mid-entry discards remaining lanes without popping; the FIFO contents are not touched.

Structure
REQ-032 Shared package fifo_pkg holds the FSM enum unpack_state_e {IDLE, HOLD} and the legal-RATIO check function.
REQ-033 An elaboration-time assertion rejects illegal IN_W/RATIO combinations.
REQ-034 The block is single-level; no sub-module is instantiated, and the FIFO instance lives in the parent.

Verification
REQ-035 Reset then FIFO holds 0xDDCCBBAA, ready=1 -> pop in cycle 1; out_data_o sequence 0xAA,0xBB,0xCC,0xDD in cycles 2-5; out_last_o only with 0xDD.
REQ-036 Two entries 0x03020100, 0x07060504 queued, ready=1 -> 8 consecutive sub-words 0x00..0x07 with no gap; second pop coincides with the 0x03 transfer.
REQ-037 ready toggles 1,0,0,1 per cycle on 0x44332211 -> each sub-word is held stable while ready=0; all four bytes are delivered in order.
REQ-038 flush_i pulse after 0x11 transfers on 0x44332211, next entry 0x88776655 present -> valid drops for one cycle, no pop that cycle, then 0x55 is output at lane 0.
REQ-039 FIFO empty after last lane, ready=1 -> IDLE, out_valid_o=0, fifo_pop_o=0; an entry arriving 3 cycles later produces valid one cycle after its pop.
REQ-040 RATIO=1, IN_W=32, entries 0xA5A5A5A5, 0x5A5A5A5A -> one transfer each, out_last_o=1 on both, back-to-back without a bubble.
